// File: rtl/addseq_ctrl_pkg.sv
// rtl/addseq_ctrl_pkg.sv - shared state encoding and byte width for the byte-serial add/subtract sequencer
package addseq_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    LOAD_X = 2'd0,
    LOAD_Y = 2'd1,
    ADD    = 2'd2,
    OUT    = 2'd3
  } state_t;

endpackage

// File: rtl/addseq_slice8.sv
// rtl/addseq_slice8.sv - combinational 8-bit ripple-carry adder slice
module addseq_slice8
  import addseq_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W-1:0] gen;
  logic [BYTE_W-1:0] prop;
  logic [BYTE_W:0]   carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
    assign gen[i]      = a_i[i] & b_i[i];
    assign prop[i]     = a_i[i] ^ b_i[i];
    assign carry[i+1]  = gen[i] | (prop[i] & carry[i]);
    assign sum[i]      = prop[i] ^ carry[i];
  end

  assign cout = carry[BYTE_W];

endmodule

// File: rtl/addseq_ctrl.sv
// rtl/addseq_ctrl.sv - loads X then Y byte-serially, adds/subtracts one byte per cycle, streams the result out
module addseq_ctrl
  import addseq_ctrl_pkg::*;
#(
  parameter int LOG2_BYTES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              op_sub,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              carry_out,
  output logic              busy
);

  localparam int BYTES = 1 << LOG2_BYTES;
  localparam logic [LOG2_BYTES-1:0] CNT_LAST = LOG2_BYTES'(BYTES - 1);

  state_t                state_q;
  state_t                state_d;
  logic [LOG2_BYTES-1:0] cnt_q;
  logic                  op_q;
  logic                  carry_q;
  logic [BYTE_W-1:0]     x_q [BYTES];
  logic [BYTE_W-1:0]     y_q [BYTES];

  logic                  cnt_last;
  logic [BYTE_W-1:0]     add_b;
  logic [BYTE_W-1:0]     add_sum;
  logic                  add_cout;

  assign cnt_last = (cnt_q == CNT_LAST);
  // Subtract is X + ~Y + 1; the +1 comes from the carry seeded with op at the end of LOAD_Y.
  assign add_b    = op_q ? ~y_q[cnt_q] : y_q[cnt_q];

  addseq_slice8 u_slice (
    .a_i  (x_q[cnt_q]),
    .b_i  (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_X;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        LOAD_X:  if (in_valid && cnt_last)  state_d = LOAD_Y;
        LOAD_Y:  if (in_valid && cnt_last)  state_d = ADD;
        ADD:     if (cnt_last)              state_d = OUT;
        OUT:     if (out_ready && cnt_last) state_d = LOAD_X;
        default:                            state_d = LOAD_X;
      endcase
    end
  end

  always_comb begin
    in_ready  = ena && ((state_q == LOAD_X) || (state_q == LOAD_Y));
    out_valid = ena && (state_q == OUT);
    busy      = (state_q == ADD) || (state_q == OUT);
    out_data  = x_q[cnt_q];
  end

  // The sum overwrites X in place, so the OUT phase reads the result from X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= 1'b0;
      carry_q   <= 1'b0;
      carry_out <= 1'b0;
      for (int i = 0; i < BYTES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else if (ena) begin
      case (state_q)
        LOAD_X: begin
          if (in_valid) begin
            x_q[cnt_q] <= in_data;
            cnt_q      <= cnt_q + 1'b1;
            if (cnt_q == '0) op_q <= op_sub;
          end
        end
        LOAD_Y: begin
          if (in_valid) begin
            y_q[cnt_q] <= in_data;
            cnt_q      <= cnt_q + 1'b1;
            if (cnt_last) carry_q <= op_q;
          end
        end
        ADD: begin
          x_q[cnt_q] <= add_sum;
          carry_q    <= add_cout;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_last) carry_out <= add_cout;
        end
        OUT: begin
          if (out_ready) cnt_q <= cnt_q + 1'b1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_addseq_ctrl.sv
// tb/tb_addseq_ctrl.sv - scoreboard bench for addseq_ctrl with LOG2_BYTES=2
module tb_addseq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       op_sub;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       carry_out;
  logic       busy;

  int         passed;
  int         total;
  int         lat;
  logic [7:0] exp_q[$];
  logic       carry_q[$];

  addseq_ctrl #(.LOG2_BYTES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .op_sub    (op_sub),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .carry_out (carry_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic sub);
    int n;
    n = 0;
    in_data  = b;
    op_sub   = sub;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_op(input logic [31:0] x, input logic [31:0] y, input logic sub, input bit gaps);
    logic [32:0] r;
    logic [31:0] xv;
    logic [31:0] yv;
    xv = x;
    yv = y;
    r = sub ? ({1'b0, xv} + {1'b0, ~yv} + 33'd1) : ({1'b0, xv} + {1'b0, yv});
    for (int i = 0; i < 4; i++) exp_q.push_back(r[8*i +: 8]);
    carry_q.push_back(r[32]);
    // op_sub is only meaningful on the first X byte; drive the opposite value elsewhere.
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      push_byte(i < 4 ? xv[8*i +: 8] : yv[8*(i-4) +: 8], (i == 0) ? sub : ~sub);
    end
  endtask

  task automatic measure_latency(input int pause_at, input int pause_len, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 200) begin
      if (cycles == pause_at) ena = 1'b0;
      if (cycles == pause_at + pause_len) ena = 1'b1;
      if (cycles == 1) begin
        check("in_ready_add", {31'd0, in_ready}, 32'd0);
        check("busy_add", {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      cycles++;
    end
    ena = 1'b1;
  endtask

  task automatic collect_bytes(input int count, input bit stall);
    int n;
    logic [7:0] hold;
    logic [7:0] expb;
    for (int i = 0; i < count; i++) begin
      n = 0;
      while (!out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) check("out_valid_timeout", 32'd0, 32'd1);
      if (stall) begin
        out_ready = 1'b0;
        hold = out_data;
        repeat (3) begin
          @(negedge clk);
          check("out_stable", {24'd0, out_data}, {24'd0, hold});
          check("in_ready_out", {31'd0, in_ready}, 32'd0);
        end
      end
      expb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("out_byte", {24'd0, out_data}, {24'd0, expb});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic check_carry();
    logic c;
    c = (carry_q.size() > 0) ? carry_q.pop_front() : 1'bx;
    check("carry_out", {31'd0, carry_out}, {31'd0, c});
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    op_sub    = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_carry_out", {31'd0, carry_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    send_op(32'h01020304, 32'h10203040, 1'b0, 1'b0);
    measure_latency(-1, 0, lat);
    check("add_latency", lat, 32'd4);
    collect_bytes(4, 1'b0);
    check_carry();

    send_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    collect_bytes(4, 1'b0);
    check_carry();

    send_op(32'h00000005, 32'h00000007, 1'b1, 1'b0);
    collect_bytes(4, 1'b0);
    check_carry();

    send_op(32'h00000007, 32'h00000005, 1'b1, 1'b0);
    collect_bytes(4, 1'b0);
    check_carry();

    send_op(32'h01020304, 32'h10203040, 1'b0, 1'b1);
    collect_bytes(4, 1'b1);
    check_carry();

    send_op(32'h01020304, 32'h10203040, 1'b0, 1'b0);
    measure_latency(2, 5, lat);
    check("ena_stall_latency", lat, 32'd9);
    collect_bytes(4, 1'b0);
    check_carry();

    send_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    collect_bytes(2, 1'b0);
    check("pre_rst_carry", {31'd0, carry_out}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_carry", {31'd0, carry_out}, 32'd0);
    exp_q.delete();
    carry_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    send_op(32'h00000010, 32'h00000020, 1'b0, 1'b0);
    collect_bytes(4, 1'b0);
    check_carry();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
